// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory, decode and control signals of the fetch stage
interface fetch_sequencer_if #(parameter int XLEN = 32);
  logic            imem_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] pc_out;
  logic            halted;
  logic            resume;
  modport master (
    output imem_en, imem_addr, inst_valid, inst, inst_pc, pc_out, halted,
    input  imem_rdata, redirect_valid, redirect_pc, inst_ready, resume
  );
  modport slave (
    input  imem_en, imem_addr, inst_valid, inst, inst_pc, pc_out, halted,
    output imem_rdata, redirect_valid, redirect_pc, inst_ready, resume
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the pc, issues imem reads and queues returned words for decode
module fetch_sequencer #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [XLEN-1:0] HALT_INSTR = XLEN'(32'h0000_0073)
) (
  input logic             clk,
  input logic             rst,
  fetch_sequencer_if.master bus
);
  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;
  logic [1:0]      state;
  logic [XLEN-1:0] pc;
  logic            inflight;
  logic [1:0]      cnt;
  logic [XLEN-1:0] q_inst [2];
  logic [XLEN-1:0] q_pc [2];
  logic            pop, flush, cap, hit, push, issue;
  logic [1:0]      wr_idx;
  // handshake, squash and issue decisions; the in-flight word's address is pc-4
  always_comb begin
    pop    = (cnt != 2'd0) & bus.inst_ready;
    flush  = bus.redirect_valid & (state != BOOT);
    cap    = inflight & !bus.redirect_valid;
    hit    = cap & (bus.imem_rdata == HALT_INSTR);
    push   = cap & !hit;
    issue  = (state == FETCH) & !bus.redirect_valid &
             (({1'b0, cnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);
    wr_idx = cnt - {1'b0, pop};
  end
  assign bus.imem_en    = issue;
  assign bus.imem_addr  = pc;
  assign bus.pc_out     = pc;
  assign bus.inst_valid = cnt != 2'd0;
  assign bus.inst       = q_inst[0];
  assign bus.inst_pc    = q_pc[0];
  assign bus.halted     = state == HALT;
  // state, pc, in-flight tracking and the two-entry shift queue (head at entry 0)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      inflight  <= 1'b0;
      cnt       <= 2'd0;
      q_inst[0] <= '0;
      q_inst[1] <= '0;
      q_pc[0]   <= '0;
      q_pc[1]   <= '0;
    end else begin
      inflight <= issue & !hit;
      state    <= state == BOOT ? FETCH : hit ? HALT :
                  (state == HALT && bus.resume) ? FETCH : state;
      pc       <= flush ? bus.redirect_pc : (issue && !hit) ? pc + XLEN'(4) : pc;
      cnt      <= flush ? 2'd0 : cnt + {1'b0, push} - {1'b0, pop};
      if (!flush) begin
        if (pop && cnt == 2'd2) begin
          q_inst[0] <= q_inst[1];
          q_pc[0]   <= q_pc[1];
        end
        if (push) begin
          q_inst[wr_idx[0]] <= bus.imem_rdata;
          q_pc[wr_idx[0]]   <= pc - XLEN'(4);
        end
      end
    end
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and sequences instruction-memory reads for the fetch stage.
- Sits between the synchronous instruction memory and decode: issues addresses, captures returned words into a 2-entry queue, presents them to decode on a valid/ready handshake.
- Handles control-flow redirects, in-flight squash, and halt/resume on a halt instruction word.

Parameters:
- XLEN, 32, address/instruction width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- HALT_INSTR, 32'h0000_0073, instruction word that halts fetch (ecall encoding)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- imem_en  output  1  read request this cycle (combinational)
- imem_addr  output  XLEN  read address, equals pc register
- imem_rdata  input  XLEN  read data, valid the cycle after imem_en=1 (fixed 1-cycle latency)
- redirect_valid  input  1  single-cycle branch/jump redirect
- redirect_pc  input  XLEN  redirect target
- inst_valid  output  1  queue head valid
- inst_ready  input  1  decode accepts head
- inst  output  XLEN  queue head instruction
- inst_pc  output  XLEN  address of inst
- pc_out  output  XLEN  current pc register (next fetch address)
- halted  output  1  1 while in HALT
- resume  input  1  leave HALT

Behaviour:
- Reset, any state: pc=RESET_PC, state=BOOT, queue empty, in-flight flag=0, halted=0, inst_valid=0, inst=0, inst_pc=0, imem_en=0. Reset asserted mid-fetch discards queue and in-flight data.
- States: BOOT -> FETCH unconditionally after one cycle. FETCH -> HALT on captured HALT_INSTR. HALT -> FETCH on resume.
- Issue rule (FETCH only): imem_en=1 when redirect_valid=0 and (occupancy + inflight - pop) < 2, where pop = inst_valid & inst_ready. On issue: inflight<=1, pc<=pc+4 (mod 2^XLEN; 32'hFFFF_FFFC wraps to 0). No issue: inflight<=0, pc held.
- Capture: in the cycle after an issue, unless squashed, push {imem_rdata, issued pc} into the queue. Same-cycle push and pop both take effect. Rule guarantees no overflow.
- Throughput: inst_ready held high gives one instruction per cycle. First inst_valid 2 cycles after BOOT exit (issue cycle, then capture edge).
- Queue: FIFO order. inst/inst_pc are registered head contents. They hold stable while inst_valid=1 and inst_ready=0. When empty, they keep the last value.
- Redirect (any state except BOOT): at the edge, pc<=redirect_pc, queue flushed, and any response arriving the next cycle is squashed. No issue in the redirect cycle. inst_valid=0 the cycle after. Fetch from redirect_pc is issued the cycle after the redirect.
- Redirect has priority over a same-cycle capture, including a HALT_INSTR capture (squashed, no halt).
- Halt: a captured word equal to HALT_INSTR is not pushed. At that edge: state<=HALT, halted<=1, pc<=halt address+4. A speculative fetch issued in the same cycle is squashed. Entries already queued still drain to decode.
- HALT: imem_en=0. Redirect updates pc and flushes the queue but stays in HALT. resume=1 -> FETCH next cycle, issuing from pc_out. resume together with redirect: pc=redirect_pc, then FETCH. resume outside HALT is ignored.
- No X on outputs after the first reset edge. imem_addr is always driven as pc.

Test Plan:
- Reset then linear run with inst_ready=1 and memory word = address: imem_addr 0,4,8,... on consecutive cycles; inst_valid rises 2 cycles after BOOT; inst_pc/inst = 0,4,8... once per cycle; pc_out advances by 4 per cycle.
- Backpressure: inst_ready=0 for 5 cycles after 0x0 is presented: queue fills to 2 (0x0, 0x4); imem_en=0 while full; inst stays 0x0. Releasing ready gives 0x0, 0x4, 0x8 with no gap and no duplicate.
- Redirect: redirect_valid pulse with redirect_pc=0x100 while 0x8 is in flight: 0x8 and queued entries are never presented; imem_en=0 in the redirect cycle; next imem_addr=0x100; next inst_pc=0x100.
- Halt: memory returns 32'h0000_0073 at 0x10: earlier entries drain; 0x10 is never presented; halted=1, pc_out=0x14, imem_en=0. resume pulse: imem_addr=0x14 next cycle, halted=0.
- Wrap and reset: RESET_PC=32'hFFFF_FFF8 gives fetches at FFFF_FFF8, FFFF_FFFC, 0000_0000. Asserting rst for one cycle mid-stream with queue full: next cycle inst_valid=0, pc_out=RESET_PC, halted=0.
- Collision: redirect_valid coincides with HALT_INSTR capture: no halt, halted stays 0, fetch resumes at redirect_pc.
